// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 encryptor, one round per clock.
// Define AES_SEQ_ABORT_EN to add the abort input.
module aes_round_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
`ifdef AES_SEQ_ABORT_EN
  ,
  input  logic         abort
`endif
);
  typedef enum logic [1:0] {IDLE, ROUND, LAST, DONE} state_t;
  state_t state, state_n;
  logic [127:0] st, st_n, sr, mc;
  logic [3:0] rnd, rnd_n;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xt(x);
    end
    return p;
  endfunction
  // Inverse is x^254 (zero maps to zero), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] p, r;
    p = b;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction
  always_comb begin
    sr = sub_shift(st);
    mc = mix_columns(sr);
  end
  assign in_ready   = state == IDLE;
  assign out_valid  = state == DONE;
  assign busy       = state != IDLE;
  assign ciphertext = st;
  assign rk_idx     = state == ROUND ? rnd : state == LAST ? 4'd10 : 4'd0;
  always_comb begin
    state_n = state;
    st_n    = st;
    rnd_n   = rnd;
    case (state)
      IDLE: if (in_valid) begin
        st_n    = plaintext ^ rk;
        rnd_n   = 4'd1;
        state_n = ROUND;
      end
      ROUND: begin
        st_n    = mc ^ rk;
        rnd_n   = rnd + 4'd1;
        state_n = rnd == 4'd9 ? LAST : ROUND;
      end
      LAST: begin
        st_n    = sr ^ rk;
        rnd_n   = 4'd0;
        state_n = DONE;
      end
      default: if (out_ready) begin
        rnd_n   = 4'd0;
        state_n = IDLE;
      end
    endcase
`ifdef AES_SEQ_ABORT_EN
    if (abort && state != IDLE) begin
      st_n    = st;
      rnd_n   = 4'd0;
      state_n = IDLE;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      st    <= '0;
      rnd   <= '0;
    end else begin
      state <= state_n;
      st    <= st_n;
      rnd   <= rnd_n;
    end
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed FIPS-197 vectors against aes_round_sequencer.
module tb_aes_round_sequencer;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [127:0] plaintext = '0, ciphertext, rk;
  logic [3:0] rk_idx;
  logic [127:0] ks [16];
  int errors = 0, checks = 0;
`ifdef AES_SEQ_ABORT_EN
  logic abort = 0;
`endif
  aes_round_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid),
    .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
`ifdef AES_SEQ_ABORT_EN
    , .abort(abort)
`endif
  );
  always #5 clk = ~clk;
  assign rk = ks[rk_idx];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] v, y;
    v = 0;
    for (int i = 1; i < 256; i++) begin
      y = 8'(i);
      if (x != 0 && gm(x, y) == 8'h01) v = y;
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) ks[r] = r < 11 ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask
  task automatic test_reset;
    rst = 1;
    step();
    rst = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags: out_valid=%b busy=%b want 0 0", out_valid, busy); end
    checks++; if (ciphertext !== 128'h0 || rk_idx !== 4'd0) begin errors++; $display("FAIL reset_regs: ct=%h rk_idx=%0d want 0 0", ciphertext, rk_idx); end
  endtask
  task automatic test_c1;
    expand(KEY_C1);
    plaintext = PT_C1;
    in_valid = 1;
    out_ready = 0;
    step();
    in_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      checks++; if (rk_idx !== 4'(k) || out_valid !== 1'b0) begin errors++; $display("FAIL c1_round%0d: rk_idx=%0d out_valid=%b want %0d 0", k, rk_idx, out_valid, k); end
      step();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL c1_latency: out_valid=%b want 1 after 10 cycles", out_valid); end
    checks++; if (ciphertext !== CT_C1) begin errors++; $display("FAIL c1_ct: got %h want %h", ciphertext, CT_C1); end
    out_ready = 1;
    step();
    out_ready = 0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL c1_handshake: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask
  task automatic test_back_to_back;
    int first, second;
    bit seen;
    expand(KEY_B);
    plaintext = PT_B;
    in_valid = 1;
    step();
    in_valid = 0;
    repeat (10) step();
    for (int i = 0; i < 6; i++) begin
      checks++; if (out_valid !== 1'b1 || ciphertext !== CT_B) begin errors++; $display("FAIL b_hold%0d: out_valid=%b ct=%h want 1 %h", i, out_valid, ciphertext, CT_B); end
      if (i < 5) step();
    end
    out_ready = 1;
    expand(KEY_C1);
    plaintext = PT_C1;
    in_valid = 1;
    first = -1;
    second = -1;
    seen = 0;
    for (int c = 0; c < 40 && second < 0; c++) begin
      if (in_ready) begin
        if (first < 0) first = c; else second = c;
      end
      if (out_valid && first >= 0 && !seen) begin
        seen = 1;
        checks++; if (ciphertext !== CT_C1) begin errors++; $display("FAIL b2b_ct: got %h want %h", ciphertext, CT_C1); end
      end
      step();
    end
    in_valid = 0;
    checks++; if (second - first !== 12) begin errors++; $display("FAIL b2b_period: got %0d want 12", second - first); end
    for (int i = 0; i < 20 && !out_valid; i++) step();
    checks++; if (out_valid !== 1'b1 || ciphertext !== CT_C1) begin errors++; $display("FAIL b2b_second: out_valid=%b ct=%h want 1 %h", out_valid, ciphertext, CT_C1); end
    step();
    out_ready = 0;
  endtask
  task automatic test_busy_reject;
    int bad;
    plaintext = PT_C1;
    in_valid = 1;
    step();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      if (in_ready !== 1'b0) bad++;
      step();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL busy_in_ready: %0d cycles high want 0", bad); end
    checks++; if (out_valid !== 1'b1 || ciphertext !== CT_C1) begin errors++; $display("FAIL busy_ct: out_valid=%b ct=%h want 1 %h", out_valid, ciphertext, CT_C1); end
    plaintext = PT_C1;
    out_ready = 1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_done_ready: got %b want 0", in_ready); end
    step();
    out_ready = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL busy_after_hs: in_ready=%b want 1", in_ready); end
    step();
    in_valid = 0;
    checks++; if (busy !== 1'b1 || rk_idx !== 4'd1) begin errors++; $display("FAIL busy_second_accept: busy=%b rk_idx=%0d want 1 1", busy, rk_idx); end
    for (int i = 0; i < 20 && !out_valid; i++) step();
    checks++; if (out_valid !== 1'b1 || ciphertext !== CT_C1) begin errors++; $display("FAIL busy_second_ct: out_valid=%b ct=%h want 1 %h", out_valid, ciphertext, CT_C1); end
    out_ready = 1;
    step();
    out_ready = 0;
  endtask
  task automatic test_reset_mid;
    plaintext = PT_C1;
    in_valid = 1;
    step();
    in_valid = 0;
    repeat (4) step();
    checks++; if (rk_idx !== 4'd5) begin errors++; $display("FAIL rstmid_rnd: rk_idx=%0d want 5", rk_idx); end
    rst = 1;
    step();
    rst = 0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
    checks++; if (ciphertext !== 128'h0 || rk_idx !== 4'd0) begin errors++; $display("FAIL rstmid_regs: ct=%h rk_idx=%0d want 0 0", ciphertext, rk_idx); end
    in_valid = 1;
    step();
    in_valid = 0;
    for (int i = 0; i < 20 && !out_valid; i++) step();
    checks++; if (out_valid !== 1'b1 || ciphertext !== CT_C1) begin errors++; $display("FAIL rstmid_ct: out_valid=%b ct=%h want 1 %h", out_valid, ciphertext, CT_C1); end
    out_ready = 1;
    step();
    out_ready = 0;
  endtask
`ifdef AES_SEQ_ABORT_EN
  task automatic test_abort;
    int pulses;
    plaintext = PT_C1;
    in_valid = 1;
    step();
    in_valid = 0;
    repeat (2) step();
    abort = 1;
    checks++; if (rk_idx !== 4'd3) begin errors++; $display("FAIL abort_rnd: rk_idx=%0d want 3", rk_idx); end
    step();
    abort = 0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: in_ready=%b busy=%b want 1 0", in_ready, busy); end
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (out_valid) pulses++;
      step();
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_out: %0d out_valid cycles want 0", pulses); end
    in_valid = 1;
    step();
    in_valid = 0;
    for (int i = 0; i < 20 && !out_valid; i++) step();
    abort = 1;
    out_ready = 1;
    step();
    abort = 0;
    out_ready = 0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_done: in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
    abort = 1;
    in_valid = 1;
    step();
    abort = 0;
    in_valid = 0;
    checks++; if (busy !== 1'b1 || rk_idx !== 4'd1) begin errors++; $display("FAIL abort_idle_accept: busy=%b rk_idx=%0d want 1 1", busy, rk_idx); end
    for (int i = 0; i < 20 && !out_valid; i++) step();
    checks++; if (out_valid !== 1'b1 || ciphertext !== CT_C1) begin errors++; $display("FAIL abort_idle_ct: out_valid=%b ct=%h want 1 %h", out_valid, ciphertext, CT_C1); end
    out_ready = 1;
    step();
    out_ready = 0;
  endtask
`endif
  initial begin
    for (int r = 0; r < 16; r++) ks[r] = '0;
    test_reset();
    test_c1();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid();
`ifdef AES_SEQ_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
